// File: rtl/median3x3_window_if.sv
// Column-in / filtered-pixel-out bundle of the 3x3 median stage.
interface median3x3_window_if #(
    parameter int unsigned PX_W = 8
);
    logic            sort_en;
    logic [PX_W-1:0] row0_px;
    logic [PX_W-1:0] row1_px;
    logic [PX_W-1:0] row2_px;
    logic            out_valid;
    logic [PX_W-1:0] out_px;
    logic [7:0]      out_col;
    logic            line_done;
    logic            frame_done;

    modport master (
        output sort_en, row0_px, row1_px, row2_px,
        input  out_valid, out_px, out_col, line_done, frame_done
    );

    modport slave (
        input  sort_en, row0_px, row1_px, row2_px,
        output out_valid, out_px, out_col, line_done, frame_done
    );
endinterface

// File: rtl/median3x3_window.sv
// 3x3 median stage of the salt-and-pepper filter: sliding 3-column window
// followed by a pipelined column-sort median network.
module median3x3_window #(
    parameter int unsigned IMG_W    = 256,
    parameter int unsigned IMG_H    = 256,
    parameter int unsigned PX_W     = 8,
    parameter int unsigned ADAPTIVE = 1
) (
    input  logic               clk,
    input  logic               res,
    median3x3_window_if.slave  px_if
);
    localparam int unsigned COL_W = 8;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef logic [PX_W-1:0] px_t;

    function automatic px_t min2(input px_t a, input px_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic px_t max2(input px_t a, input px_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic px_t med3(input px_t a, input px_t b, input px_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    logic [COL_W-1:0] col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
    px_t              lo_q [3];
    px_t              mid_q[3];
    px_t              hi_q [3];
    px_t              cen2_q, cen1_q;

    logic             a_vld_q, a_vld_d;
    logic             a_ll_q, a_ll_d;
    logic             a_fl_q, a_fl_d;
    logic [COL_W-1:0] a_col_q, a_col_d;

    px_t              b_max_q, b_med_q, b_min_q, b_cen_q;
    logic             b_vld_q, b_ll_q, b_fl_q;
    logic [COL_W-1:0] b_col_q;

    px_t              c_med_d, c_px_d;

    logic             out_valid_q, line_done_q, frame_done_q;
    px_t              out_px_q;
    logic [COL_W-1:0] out_col_q;

    // Column/line counters and result launch for the column accepted this edge
    always_comb begin
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        a_vld_d   = 1'b0;
        a_ll_d    = 1'b0;
        a_fl_d    = 1'b0;
        a_col_d   = col_cnt_q - COL_W'(1);
        if (px_if.sort_en) begin
            a_vld_d = (col_cnt_q >= COL_W'(2));
            a_ll_d  = (col_cnt_q == COL_W'(IMG_W - 1));
            a_fl_d  = a_ll_d && (row_cnt_q == ROW_W'(IMG_H - 1));
            if (a_ll_d) begin
                col_cnt_d = '0;
                row_cnt_d = a_fl_d ? '0 : row_cnt_q + ROW_W'(1);
            end else begin
                col_cnt_d = col_cnt_q + COL_W'(1);
            end
        end
    end

    // Final median and adaptive centre-replacement decision
    always_comb begin
        c_med_d = med3(b_max_q, b_med_q, b_min_q);
        c_px_d  = c_med_d;
        if ((ADAPTIVE != 0) && (b_cen_q != '0) && (b_cen_q != '1)) begin
            c_px_d = b_cen_q;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                lo_q[i]  <= '0;
                mid_q[i] <= '0;
                hi_q[i]  <= '0;
            end
            cen2_q       <= '0;
            cen1_q       <= '0;
            a_vld_q      <= 1'b0;
            a_ll_q       <= 1'b0;
            a_fl_q       <= 1'b0;
            a_col_q      <= '0;
            b_max_q      <= '0;
            b_med_q      <= '0;
            b_min_q      <= '0;
            b_cen_q      <= '0;
            b_vld_q      <= 1'b0;
            b_ll_q       <= 1'b0;
            b_fl_q       <= 1'b0;
            b_col_q      <= '0;
            out_valid_q  <= 1'b0;
            out_px_q     <= '0;
            out_col_q    <= '0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            a_vld_q   <= a_vld_d;
            a_ll_q    <= a_ll_d;
            a_fl_q    <= a_fl_d;
            a_col_q   <= a_col_d;

            // Stage A: sorted column enters the window, raw row1 tracked for the centre
            if (px_if.sort_en) begin
                lo_q[0]  <= lo_q[1];
                lo_q[1]  <= lo_q[2];
                lo_q[2]  <= min2(min2(px_if.row0_px, px_if.row1_px), px_if.row2_px);
                mid_q[0] <= mid_q[1];
                mid_q[1] <= mid_q[2];
                mid_q[2] <= med3(px_if.row0_px, px_if.row1_px, px_if.row2_px);
                hi_q[0]  <= hi_q[1];
                hi_q[1]  <= hi_q[2];
                hi_q[2]  <= max2(max2(px_if.row0_px, px_if.row1_px), px_if.row2_px);
                cen1_q   <= cen2_q;
                cen2_q   <= px_if.row1_px;
            end

            // Stage B: cross-column reduction
            b_max_q <= max2(max2(lo_q[0], lo_q[1]), lo_q[2]);
            b_med_q <= med3(mid_q[0], mid_q[1], mid_q[2]);
            b_min_q <= min2(min2(hi_q[0], hi_q[1]), hi_q[2]);
            b_cen_q <= cen1_q;
            b_vld_q <= a_vld_q;
            b_ll_q  <= a_ll_q;
            b_fl_q  <= a_fl_q;
            b_col_q <= a_col_q;

            // Stage C: output register, pixel and column hold between results
            out_valid_q  <= b_vld_q;
            line_done_q  <= b_vld_q && b_ll_q;
            frame_done_q <= b_vld_q && b_fl_q;
            if (b_vld_q) begin
                out_px_q  <= c_px_d;
                out_col_q <= b_col_q;
            end
        end
    end

    assign px_if.out_valid  = out_valid_q;
    assign px_if.out_px     = out_px_q;
    assign px_if.out_col    = out_col_q;
    assign px_if.line_done  = line_done_q;
    assign px_if.frame_done = frame_done_q;

endmodule

// File: tb/tb_median3x3_window.sv
// Bench for median3x3_window: three instances (adaptive, non-adaptive, 8x4 frame)
// share one input stream and are checked against a 9-pixel sorting reference.
module tb_median3x3_window;
    logic       clk = 1'b0;
    logic       res;
    logic       sort_en;
    logic [7:0] r0, r1, r2;

    always #5 clk = ~clk;

    median3x3_window_if #(.PX_W(8)) if_a1 ();
    median3x3_window_if #(.PX_W(8)) if_a0 ();
    median3x3_window_if #(.PX_W(8)) if_s  ();

    assign if_a1.sort_en = sort_en; assign if_a1.row0_px = r0; assign if_a1.row1_px = r1; assign if_a1.row2_px = r2;
    assign if_a0.sort_en = sort_en; assign if_a0.row0_px = r0; assign if_a0.row1_px = r1; assign if_a0.row2_px = r2;
    assign if_s.sort_en  = sort_en; assign if_s.row0_px  = r0; assign if_s.row1_px  = r1; assign if_s.row2_px  = r2;

    median3x3_window #(.IMG_W(256), .IMG_H(256), .PX_W(8), .ADAPTIVE(1)) u_a1 (.clk(clk), .res(res), .px_if(if_a1));
    median3x3_window #(.IMG_W(256), .IMG_H(256), .PX_W(8), .ADAPTIVE(0)) u_a0 (.clk(clk), .res(res), .px_if(if_a0));
    median3x3_window #(.IMG_W(8),   .IMG_H(4),   .PX_W(8), .ADAPTIVE(1)) u_s  (.clk(clk), .res(res), .px_if(if_s));

    logic       ov  [3];
    logic [7:0] opx [3];
    logic [7:0] ocol[3];
    logic       old [3];
    logic       ofd [3];

    assign ov[0] = if_a1.out_valid; assign opx[0] = if_a1.out_px; assign ocol[0] = if_a1.out_col;
    assign old[0] = if_a1.line_done; assign ofd[0] = if_a1.frame_done;
    assign ov[1] = if_a0.out_valid; assign opx[1] = if_a0.out_px; assign ocol[1] = if_a0.out_col;
    assign old[1] = if_a0.line_done; assign ofd[1] = if_a0.frame_done;
    assign ov[2] = if_s.out_valid;  assign opx[2] = if_s.out_px;  assign ocol[2] = if_s.out_col;
    assign old[2] = if_s.line_done;  assign ofd[2] = if_s.frame_done;

    typedef struct {
        logic       v;
        logic [7:0] px;
        logic [7:0] col;
        logic       ld;
        logic       fd;
    } exp_t;

    exp_t       dl     [3][3];
    int         mcol   [3];
    int         mrow   [3];
    logic [7:0] hist   [3][2][3];
    logic [7:0] hold_px[3];
    int         pulses [3];
    int         fdones [3];
    int         first_col[3];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         p0, p1, p2, f2;

    function automatic int img_w(input int d);
        return (d == 2) ? 8 : 256;
    endfunction

    function automatic int img_h(input int d);
        return (d == 2) ? 4 : 256;
    endfunction

    function automatic bit adaptive(input int d);
        return d != 1;
    endfunction

    function automatic logic [7:0] median9(input logic [7:0] v[9]);
        logic [7:0] s[9];
        logic [7:0] t;
        s = v;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        return s[4];
    endfunction

    function automatic logic [7:0] rpx();
        int k;
        k = int'($urandom_range(0, 9));
        if (k == 0) return 8'd0;
        if (k == 1) return 8'd255;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            mcol[d] = 0;
            mrow[d] = 0;
            hold_px[d] = 8'd0;
            for (int s = 0; s < 3; s++) dl[d][s] = '{default: 0};
        end
    endtask

    // One cycle: check what is visible now, then drive the next edge and predict it
    task automatic step(input logic en, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic rst);
        exp_t       e;
        logic [7:0] win[9];
        logic [7:0] cen;
        logic [7:0] col_px[3];
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            e = dl[d][2];
            if (e.v) hold_px[d] = e.px;
            chk($sformatf("out_valid[%0d]", d), 32'(ov[d]), 32'(e.v));
            chk($sformatf("out_px[%0d]", d), 32'(opx[d]), 32'(hold_px[d]));
            chk($sformatf("line_done[%0d]", d), 32'(old[d]), 32'(e.v && e.ld));
            chk($sformatf("frame_done[%0d]", d), 32'(ofd[d]), 32'(e.v && e.fd));
            if (e.v) chk($sformatf("out_col[%0d]", d), 32'(ocol[d]), 32'(e.col));
            if (ov[d]) begin
                pulses[d]++;
                if (first_col[d] < 0) first_col[d] = int'(ocol[d]);
            end
            if (ofd[d]) fdones[d]++;
            dl[d][2] = dl[d][1];
            dl[d][1] = dl[d][0];
            dl[d][0] = '{default: 0};
        end
        sort_en = en; r0 = a; r1 = b; r2 = c; res = rst;
        col_px[0] = a; col_px[1] = b; col_px[2] = c;
        if (rst) begin
            model_reset();
        end else if (en) begin
            for (int d = 0; d < 3; d++) begin
                if (mcol[d] >= 2) begin
                    for (int r = 0; r < 3; r++) begin
                        win[r]     = hist[d][0][r];
                        win[3 + r] = hist[d][1][r];
                        win[6 + r] = col_px[r];
                    end
                    cen   = hist[d][1][1];
                    e.v   = 1'b1;
                    e.px  = (adaptive(d) && cen != 8'd0 && cen != 8'd255) ? cen : median9(win);
                    e.col = 8'(mcol[d] - 1);
                    e.ld  = (mcol[d] == img_w(d) - 1);
                    e.fd  = e.ld && (mrow[d] == img_h(d) - 1);
                    dl[d][0] = e;
                end
                hist[d][0] = hist[d][1];
                for (int r = 0; r < 3; r++) hist[d][1][r] = col_px[r];
                if (mcol[d] == img_w(d) - 1) begin
                    mcol[d] = 0;
                    mrow[d] = (mrow[d] == img_h(d) - 1) ? 0 : mrow[d] + 1;
                end else begin
                    mcol[d]++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    endtask

    initial begin
        res = 1'b1; sort_en = 1'b0; r0 = '0; r1 = '0; r2 = '0;
        model_reset();
        for (int d = 0; d < 3; d++) begin
            pulses[d] = 0; fdones[d] = 0; first_col[d] = -1;
        end
        repeat (2) @(posedge clk);
        do_reset();
        idle(1);
        chk("reset_out_col", 32'(ocol[0]), 32'd0);

        // Uniform line of 100s
        p0 = pulses[0];
        for (int d = 0; d < 3; d++) first_col[d] = -1;
        repeat (256) step(1'b1, 8'd100, 8'd100, 8'd100, 1'b0);
        idle(3);
        chk("fill_pulses", 32'(pulses[0] - p0), 32'd254);
        chk("fill_first_col", 32'(first_col[0]), 32'd1);

        // Salt outlier in the centre
        do_reset();
        step(1'b1, 8'd10, 8'd10,  8'd10, 1'b0);
        step(1'b1, 8'd10, 8'd255, 8'd10, 1'b0);
        step(1'b1, 8'd10, 8'd10,  8'd10, 1'b0);
        idle(4);
        chk("salt_adaptive", 32'(opx[0]), 32'd10);
        chk("salt_plain", 32'(opx[1]), 32'd10);

        // Non-extreme centre: kept when adaptive, true median (6) otherwise
        do_reset();
        step(1'b1, 8'd1, 8'd2,   8'd3, 1'b0);
        step(1'b1, 8'd4, 8'd200, 8'd6, 1'b0);
        step(1'b1, 8'd7, 8'd8,   8'd9, 1'b0);
        idle(4);
        chk("pass_adaptive", 32'(opx[0]), 32'd200);
        chk("pass_plain", 32'(opx[1]), 32'd6);

        // One line with sort_en toggling every cycle
        do_reset();
        p0 = pulses[0]; p1 = pulses[1]; p2 = pulses[2];
        for (int i = 0; i < 512; i++) step((i % 2) == 0, rpx(), rpx(), rpx(), 1'b0);
        idle(3);
        chk("gap_pulses_a1", 32'(pulses[0] - p0), 32'd254);
        chk("gap_pulses_a0", 32'(pulses[1] - p1), 32'd254);
        chk("gap_pulses_small", 32'(pulses[2] - p2), 32'd192);

        // Reset after 50 columns, sort_en held high through it
        do_reset();
        repeat (50) step(1'b1, rpx(), rpx(), rpx(), 1'b0);
        step(1'b1, rpx(), rpx(), rpx(), 1'b1);
        first_col[0] = -1;
        repeat (10) step(1'b1, rpx(), rpx(), rpx(), 1'b0);
        idle(3);
        chk("restart_first_col", 32'(first_col[0]), 32'd1);

        // Full 8x4 frame on the small instance, then the start of the next frame
        do_reset();
        p2 = pulses[2]; f2 = fdones[2];
        repeat (32) step(1'b1, rpx(), rpx(), rpx(), 1'b0);
        idle(3);
        chk("frame_pulses", 32'(pulses[2] - p2), 32'd24);
        chk("frame_done_count", 32'(fdones[2] - f2), 32'd1);
        first_col[2] = -1;
        repeat (8) step(1'b1, rpx(), rpx(), rpx(), 1'b0);
        idle(3);
        chk("next_frame_first_col", 32'(first_col[2]), 32'd1);

        // Random soak with gaps and occasional resets
        repeat (800) step($urandom_range(0, 3) != 0, rpx(), rpx(), rpx(), $urandom_range(0, 199) == 0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
